// File: rtl/boid_state_ram.sv
// Boid state store (x, y, vx, vy, vx_acc, vy_acc): port A 1-cycle reads and masked writes; port B occupancy scan, result NUM_BOIDS+2 cycles after chk_start.
// No backpressure: requests are dropped while init_busy, chk_start is dropped while busy; BOID_MEM_HIT_IDX_EN adds hit_idx.
module boid_state_ram #(
  parameter int NUM_BOIDS = 16,
  parameter int IDX_W     = $clog2(NUM_BOIDS),
  parameter int X0        = 120,
  parameter int Y0        = 120,
  parameter int SPACING   = 40,
  parameter int VX0       = 5,
  parameter int VY0       = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             init_busy,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [31:0]      x_out_32,
  output logic [31:0]      y_out_32,
  output logic [31:0]      vx_out_32,
  output logic [31:0]      vy_out_32,
  output logic [31:0]      vx_acc_out,
  output logic [31:0]      vy_acc_out,
  input  logic [6:0]       wb_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      x_in_32,
  input  logic [31:0]      y_in_32,
  input  logic [31:0]      vx_in_32,
  input  logic [31:0]      vy_in_32,
  input  logic [31:0]      vx_acc_in,
  input  logic [31:0]      vy_acc_in,
  input  logic             chk_start,
  input  logic [31:0]      x_chk_in,
  input  logic [31:0]      y_chk_in,
  output logic             chk_busy,
  output logic             chk_done,
  output logic             is_boid_here
`ifdef BOID_MEM_HIT_IDX_EN
  ,
  output logic [IDX_W-1:0] hit_idx
`endif
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [IDX_W:0]   NB      = (IDX_W+1)'(NUM_BOIDS);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_BOIDS - 1);
  localparam logic [31:0]      VX_INIT = 32'(VX0) << 16;
  localparam logic [31:0]      VY_INIT = 32'(VY0) << 16;

  // Field storage: fixed-point 16-bit fraction, widths chosen per field.
  logic [27:0] mem_x     [NUM_BOIDS];
  logic [26:0] mem_y     [NUM_BOIDS];
  logic [20:0] mem_vx    [NUM_BOIDS];
  logic [20:0] mem_vy    [NUM_BOIDS];
  logic [31:0] mem_vxacc [NUM_BOIDS];
  logic [31:0] mem_vyacc [NUM_BOIDS];

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic [IDX_W:0]   sc_cnt_q, sc_cnt_d;
  logic [31:0]      x_chk_q, x_chk_d, y_chk_q, y_chk_d;
  logic             hit_acc_q, hit_acc_d, is_here_q, is_here_d;
  logic             b_vld_q, rd_valid_q, rd_ok_q;

  logic             in_init, wr_user, rd_acc, b_issue, scan_end, b_hit, b_hit_v;
  logic [IDX_W-1:0] wa, b_addr;
  logic [6:1]       we;
  logic [31:0]      init_x, init_y, bx_int, by_int;

  logic [27:0] ra_x_q, rb_x_q;
  logic [26:0] ra_y_q, rb_y_q;
  logic [20:0] ra_vx_q, ra_vy_q;
  logic [31:0] ra_vxacc_q, ra_vyacc_q;

  assign in_init   = (state_q == ST_INIT);
  assign init_busy = in_init;
  assign chk_busy  = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign chk_done  = (state_q == ST_DONE);
  assign is_boid_here = is_here_q;
  assign rd_valid  = rd_valid_q;

  assign init_x = (32'(X0) + 32'(SPACING) * 32'(init_cnt_q)) << 16;
  assign init_y = (32'(Y0) + 32'(SPACING) * 32'(init_cnt_q)) << 16;

  assign wr_user = !reset && !in_init && wb_en[0] && ({1'b0, wr_idx} < NB);
  assign we      = {6{in_init}} | ({6{wr_user}} & wb_en[6:1]);
  assign wa      = in_init ? init_cnt_q : wr_idx;
  assign rd_acc  = rd_en && !in_init && !reset;

  assign b_issue  = (state_q == ST_SCAN) && (sc_cnt_q != NB);
  assign scan_end = (state_q == ST_SCAN) && (sc_cnt_q == NB);
  assign b_addr   = sc_cnt_q[IDX_W-1:0];
  assign bx_int   = {{20{rb_x_q[27]}}, rb_x_q[27:16]};
  assign by_int   = {{21{rb_y_q[26]}}, rb_y_q[26:16]};
  assign b_hit    = (bx_int == x_chk_q) && (by_int == y_chk_q);
  assign b_hit_v  = b_vld_q && b_hit;

  // Memories carry no reset; read registers sample the pre-write contents.
  always_ff @(posedge clk) begin
    if (we[1]) mem_x[wa]     <= in_init ? init_x[27:0]   : x_in_32[27:0];
    if (we[2]) mem_y[wa]     <= in_init ? init_y[26:0]   : y_in_32[26:0];
    if (we[3]) mem_vx[wa]    <= in_init ? VX_INIT[20:0]  : vx_in_32[20:0];
    if (we[4]) mem_vy[wa]    <= in_init ? VY_INIT[20:0]  : vy_in_32[20:0];
    if (we[5]) mem_vxacc[wa] <= in_init ? 32'd0          : vx_acc_in;
    if (we[6]) mem_vyacc[wa] <= in_init ? 32'd0          : vy_acc_in;
    if (rd_acc) begin
      ra_x_q     <= mem_x[rd_idx];
      ra_y_q     <= mem_y[rd_idx];
      ra_vx_q    <= mem_vx[rd_idx];
      ra_vy_q    <= mem_vy[rd_idx];
      ra_vxacc_q <= mem_vxacc[rd_idx];
      ra_vyacc_q <= mem_vyacc[rd_idx];
    end
    if (b_issue) begin
      rb_x_q <= mem_x[b_addr];
      rb_y_q <= mem_y[b_addr];
    end
  end

  assign x_out_32   = rd_ok_q ? {{4{ra_x_q[27]}}, ra_x_q}    : 32'd0;
  assign y_out_32   = rd_ok_q ? {{5{ra_y_q[26]}}, ra_y_q}    : 32'd0;
  assign vx_out_32  = rd_ok_q ? {{11{ra_vx_q[20]}}, ra_vx_q} : 32'd0;
  assign vy_out_32  = rd_ok_q ? {{11{ra_vy_q[20]}}, ra_vy_q} : 32'd0;
  assign vx_acc_out = rd_ok_q ? ra_vxacc_q : 32'd0;
  assign vy_acc_out = rd_ok_q ? ra_vyacc_q : 32'd0;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    sc_cnt_d   = sc_cnt_q;
    x_chk_d    = x_chk_q;
    y_chk_d    = y_chk_q;
    hit_acc_d  = hit_acc_q;
    is_here_d  = is_here_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST) begin
          state_d    = ST_IDLE;
          init_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (chk_start) begin
          state_d   = ST_SCAN;
          sc_cnt_d  = '0;
          x_chk_d   = x_chk_in;
          y_chk_d   = y_chk_in;
          hit_acc_d = 1'b0;
        end
      end
      ST_SCAN: begin
        hit_acc_d = hit_acc_q | b_hit_v;
        if (scan_end) begin
          state_d   = ST_DONE;
          is_here_d = hit_acc_q | b_hit_v;
        end else begin
          sc_cnt_d = sc_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      sc_cnt_q   <= '0;
      x_chk_q    <= '0;
      y_chk_q    <= '0;
      hit_acc_q  <= 1'b0;
      is_here_q  <= 1'b0;
      b_vld_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      sc_cnt_q   <= sc_cnt_d;
      x_chk_q    <= x_chk_d;
      y_chk_q    <= y_chk_d;
      hit_acc_q  <= hit_acc_d;
      is_here_q  <= is_here_d;
      b_vld_q    <= b_issue;
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_ok_q <= ({1'b0, rd_idx} < NB);
    end
  end

`ifdef BOID_MEM_HIT_IDX_EN
  logic [IDX_W-1:0] b_idx_q, first_idx_q, first_idx_d, hit_idx_q, hit_idx_d;

  // First hit wins, giving the lowest matching index since the scan runs upward.
  always_comb begin
    first_idx_d = first_idx_q;
    hit_idx_d   = hit_idx_q;
    if (b_hit_v && !hit_acc_q) first_idx_d = b_idx_q;
    if (scan_end) hit_idx_d = (hit_acc_q | b_hit_v) ? first_idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_idx_q     <= '0;
      first_idx_q <= '0;
      hit_idx_q   <= '0;
    end else begin
      b_idx_q     <= b_addr;
      first_idx_q <= first_idx_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  assign hit_idx = hit_idx_q;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, x_in_32[31:28], y_in_32[31:27], vx_in_32[31:21], vy_in_32[31:21],
                       init_x[31:28], init_y[31:27], rb_x_q[15:0], rb_y_q[15:0]};

endmodule

// File: tb/tb_boid_state_ram.sv
// Directed bench for boid_state_ram with default parameters (16 boids).
module tb_boid_state_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_busy, rd_en, rd_valid;
  logic [3:0]  rd_idx, wr_idx;
  logic [31:0] x_out_32, y_out_32, vx_out_32, vy_out_32, vx_acc_out, vy_acc_out;
  logic [6:0]  wb_en;
  logic [31:0] x_in_32, y_in_32, vx_in_32, vy_in_32, vx_acc_in, vy_acc_in;
  logic        chk_start, chk_busy, chk_done, is_boid_here;
  logic [31:0] x_chk_in, y_chk_in;
`ifdef BOID_MEM_HIT_IDX_EN
  logic [3:0]  hit_idx;
`endif

  int n_pass  = 0;
  int n_total = 0;

  boid_state_ram dut (
    .clk(clk), .reset(reset), .init_busy(init_busy),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .x_out_32(x_out_32), .y_out_32(y_out_32), .vx_out_32(vx_out_32), .vy_out_32(vy_out_32),
    .vx_acc_out(vx_acc_out), .vy_acc_out(vy_acc_out),
    .wb_en(wb_en), .wr_idx(wr_idx),
    .x_in_32(x_in_32), .y_in_32(y_in_32), .vx_in_32(vx_in_32), .vy_in_32(vy_in_32),
    .vx_acc_in(vx_acc_in), .vy_acc_in(vy_acc_in),
    .chk_start(chk_start), .x_chk_in(x_chk_in), .y_chk_in(y_chk_in),
    .chk_busy(chk_busy), .chk_done(chk_done), .is_boid_here(is_boid_here)
`ifdef BOID_MEM_HIT_IDX_EN
    , .hit_idx(hit_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] idx);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] mask, input logic [3:0] idx,
                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] vx,
                          input logic [31:0] vy, input logic [31:0] vxa, input logic [31:0] vya);
    wb_en = mask; wr_idx = idx;
    x_in_32 = x; y_in_32 = y; vx_in_32 = vx; vy_in_32 = vy; vx_acc_in = vxa; vy_acc_in = vya;
    tick();
    wb_en = 7'b0;
  endtask

  task automatic wait_init(input string tag);
    int k;
    k = 0;
    while (init_busy && k < 40) begin
      tick();
      k++;
    end
    check(tag, 32'(k), 32'd16);
  endtask

  // chk_done must arrive exactly 18 (NUM_BOIDS+2) cycles after chk_start.
  task automatic do_scan(input string tag, input logic [31:0] xc, input logic [31:0] yc,
                         input bit extra, input logic exp_here, input logic [3:0] exp_idx);
    int done_at;
    done_at   = -1;
    chk_start = 1'b1;
    x_chk_in  = xc;
    y_chk_in  = yc;
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      tick();
      chk_start = extra && (k == 4);
      if (k == 1) check({tag, "_busy"}, 32'(chk_busy), 32'd1);
      if (chk_done) done_at = k;
    end
    chk_start = 1'b0;
    check({tag, "_latency"}, 32'(done_at), 32'd18);
    check({tag, "_here"}, 32'(is_boid_here), 32'(exp_here));
`ifdef BOID_MEM_HIT_IDX_EN
    check({tag, "_hit_idx"}, 32'(hit_idx), 32'(exp_idx));
`else
    if (exp_idx == 4'hF) $display("note: unused index");
`endif
  endtask

  initial begin
    int pulses;
    reset = 1'b1; rd_en = 1'b0; rd_idx = '0; wb_en = '0; wr_idx = '0;
    x_in_32 = '0; y_in_32 = '0; vx_in_32 = '0; vy_in_32 = '0; vx_acc_in = '0; vy_acc_in = '0;
    chk_start = 1'b0; x_chk_in = '0; y_chk_in = '0;
    repeat (3) tick();

    check("rst_init_busy", 32'(init_busy), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_chk_busy", 32'(chk_busy), 32'd0);
    check("rst_chk_done", 32'(chk_done), 32'd0);
    check("rst_here", 32'(is_boid_here), 32'd0);
    check("rst_x_out", x_out_32, 32'd0);

    reset = 1'b0;
    wait_init("init_cycles");

    do_read(4'd3);
    check("rd3_valid", 32'(rd_valid), 32'd1);
    check("rd3_x", x_out_32, 32'h00F00000);
    check("rd3_y", y_out_32, 32'h00F00000);
    check("rd3_vx", vx_out_32, 32'h00050000);
    check("rd3_vy", vy_out_32, 32'h00040000);
    check("rd3_vxacc", vx_acc_out, 32'd0);
    check("rd3_vyacc", vy_acc_out, 32'd0);
    tick();
    check("rd3_valid_drop", 32'(rd_valid), 32'd0);
    check("rd3_x_hold", x_out_32, 32'h00F00000);

    do_scan("scan_hit", 32'd160, 32'd160, 1'b0, 1'b1, 4'd1);
    tick();
    do_scan("scan_miss", 32'd161, 32'd160, 1'b1, 1'b0, 4'd0);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (chk_done) pulses++;
    end
    check("no_extra_done", 32'(pulses), 32'd0);
    check("miss_held", 32'(is_boid_here), 32'd0);

    do_write(7'b0000011, 4'd2, 32'hFFF00000, 32'h12345678, 32'h1, 32'h1, 32'h1, 32'h1);
    do_read(4'd2);
    check("wr2_x", x_out_32, 32'hFFF00000);
    check("wr2_y_kept", y_out_32, 32'h00C80000);
    check("wr2_vx_kept", vx_out_32, 32'h00050000);
    do_scan("scan_neg", 32'hFFFFFFF0, 32'd200, 1'b0, 1'b1, 4'd2);

    do_write(7'b1111111, 4'd5, 32'h0ABCDEF0, 32'h12345678, 32'h00001234, 32'h12345678,
             32'hDEADBEEF, 32'h80000001);
    do_read(4'd5);
    check("wr5_x_trunc", x_out_32, 32'hFABCDEF0);
    check("wr5_y_trunc", y_out_32, 32'h02345678);
    check("wr5_vx", vx_out_32, 32'h00001234);
    check("wr5_vy_trunc", vy_out_32, 32'hFFF45678);
    check("wr5_vxacc", vx_acc_out, 32'hDEADBEEF);
    check("wr5_vyacc", vy_acc_out, 32'h80000001);

    // Read and write of the same boid in one cycle.
    rd_en = 1'b1; rd_idx = 4'd0;
    do_write(7'b0000011, 4'd0, 32'h00640000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    rd_en = 1'b0;
    check("rbw_old", x_out_32, 32'h00780000);
    do_read(4'd0);
    check("rbw_new", x_out_32, 32'h00640000);

    chk_start = 1'b1; x_chk_in = 32'd160; y_chk_in = 32'd160;
    tick();
    chk_start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_init_busy", 32'(init_busy), 32'd1);
    check("abort_chk_busy", 32'(chk_busy), 32'd0);
    check("abort_here", 32'(is_boid_here), 32'd0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (chk_done) pulses++;
      tick();
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_init_done", 32'(init_busy), 32'd0);
    do_read(4'd2);
    check("reload2_x", x_out_32, 32'h00C80000);
    do_read(4'd5);
    check("reload5_vyacc", vy_acc_out, 32'd0);
    check("reload5_vy", vy_out_32, 32'h00040000);
    do_read(4'd0);
    check("reload0_x", x_out_32, 32'h00780000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
